// File: rtl/beam_pwr_topk.sv
`default_nettype none
// ============================================================================
// beam_pwr_topk: per-beam truncated power, accumulated over one symbol into a
// double-buffered snapshot, followed by a sequential top-K beam selection.
// Revision: 1.0
// ============================================================================
module beam_pwr_topk #(
   parameter int BEAM = 16,
   parameter int OW   = 48,
   parameter int SW   = 24,
   parameter int NRE  = 1584,
   parameter int K    = 4,
   parameter int AW   = 64,
   parameter int IDXW = $clog2(BEAM)
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [BEAM-1:0][2*OW-1:0]    i_sum_data,
   input  logic                         i_tvalid,
   input  logic                         i_sym_start,
   output logic [K-1:0][IDXW-1:0]       o_beam_idx,
   output logic [K-1:0][AW-1:0]         o_beam_pwr,
   output logic                         o_idx_valid,
   output logic                         o_busy,
   output logic                         o_drop
);
   localparam int CW = $clog2(NRE + 1);
   localparam int PW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, EMIT = 2'd2} state_t;

   logic [BEAM-1:0][SW-1:0]   re1_q, im1_q;
   logic [BEAM-1:0][2*SW-1:0] rr2_q, ii2_q;
   logic [BEAM-1:0][AW-1:0]   p3_q;
   logic [2:0]                vld_q, st_q;
   logic [BEAM-1:0][AW-1:0]   acc_q, acc_d, snap_q, snap_d;
   logic [CW-1:0]             cnt_q, cnt_d, eff_cnt;
   logic                      first_re;
   logic                      snap_rdy_q, snap_rdy_d, drop_q, drop_d;

   state_t                    state_q, state_d;
   logic [IDXW-1:0]           j_q, j_d, bidx_q, bidx_d, nidx;
   logic [AW-1:0]             bpwr_q, bpwr_d, npwr;
   logic                      have_q, have_d, take;
   logic [PW-1:0]             pass_q, pass_d;
   logic [BEAM-1:0]           mask_q, mask_d;
   logic [K-1:0][IDXW-1:0]    ridx_q, ridx_d, oidx_q, oidx_d;
   logic [K-1:0][AW-1:0]      rpwr_q, rpwr_d, opwr_q, opwr_d;

   logic unused_lsbs;
   assign unused_lsbs = ^i_sum_data;

   function automatic logic [2*SW-1:0] sq(input logic [SW-1:0] x);
      logic signed [2*SW-1:0] xe;
      xe = {{SW{x[SW-1]}}, x};
      return xe * xe;
   endfunction

   // Power pipe: truncate, square, sum; valid/start travel alongside.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         re1_q <= '0; im1_q <= '0; rr2_q <= '0; ii2_q <= '0; p3_q <= '0;
         vld_q <= '0; st_q  <= '0;
      end else begin
         vld_q <= {vld_q[1:0], i_tvalid};
         st_q  <= {st_q[1:0], i_tvalid & i_sym_start};
         for (int b = 0; b < BEAM; b++) begin
            re1_q[b] <= i_sum_data[b][2*OW-1 -: SW];
            im1_q[b] <= i_sum_data[b][OW-1 -: SW];
            rr2_q[b] <= sq(re1_q[b]);
            ii2_q[b] <= sq(im1_q[b]);
            p3_q[b]  <= AW'(rr2_q[b] + ii2_q[b]);
         end
      end
   end

   // The snapshot may be overwritten whenever the sorter is not reading it.
   always_comb begin
      acc_d      = acc_q;
      snap_d     = snap_q;
      cnt_d      = cnt_q;
      drop_d     = 1'b0;
      snap_rdy_d = (state_q == IDLE) ? 1'b0 : snap_rdy_q;
      first_re   = (cnt_q == '0) || st_q[2];
      eff_cnt    = first_re ? '0 : cnt_q;
      if (vld_q[2]) begin
         for (int b = 0; b < BEAM; b++)
            acc_d[b] = (first_re ? '0 : acc_q[b]) + p3_q[b];
         if (eff_cnt == CW'(NRE - 1)) begin
            cnt_d = '0;
            if (state_q != SCAN) begin
               snap_d     = acc_d;
               snap_rdy_d = 1'b1;
            end else begin
               drop_d = 1'b1;
            end
         end else begin
            cnt_d = eff_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      pass_d  = pass_q;
      mask_d  = mask_q;
      have_d  = have_q;
      bidx_d  = bidx_q;
      bpwr_d  = bpwr_q;
      ridx_d  = ridx_q;
      rpwr_d  = rpwr_q;
      oidx_d  = oidx_q;
      opwr_d  = opwr_q;
      take    = 1'b0;
      nidx    = bidx_q;
      npwr    = bpwr_q;
      case (state_q)
         IDLE: begin
            if (snap_rdy_q) begin
               state_d = SCAN;
               j_d     = '0;
               pass_d  = '0;
               mask_d  = '0;
               have_d  = 1'b0;
            end
         end
         SCAN: begin
            // Strict compare keeps the lowest index on ties.
            take = !mask_q[j_q] && (!have_q || (snap_q[j_q] > bpwr_q));
            if (take) begin
               nidx = j_q;
               npwr = snap_q[j_q];
            end
            if (j_q == IDXW'(BEAM - 1)) begin
               ridx_d[pass_q] = nidx;
               rpwr_d[pass_q] = npwr;
               mask_d[nidx]   = 1'b1;
               pass_d         = pass_q + PW'(1);
               j_d            = '0;
               have_d         = 1'b0;
               if (pass_q == PW'(K - 1)) begin
                  state_d = EMIT;
                  oidx_d  = ridx_d;
                  opwr_d  = rpwr_d;
               end
            end else begin
               j_d    = j_q + IDXW'(1);
               bidx_d = nidx;
               bpwr_d = npwr;
               have_d = have_q | take;
            end
         end
         EMIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_q <= '0; snap_q <= '0; cnt_q <= '0; snap_rdy_q <= 1'b0; drop_q <= 1'b0;
         state_q <= IDLE; j_q <= '0; pass_q <= '0; mask_q <= '0; have_q <= 1'b0;
         bidx_q <= '0; bpwr_q <= '0; ridx_q <= '0; rpwr_q <= '0;
         oidx_q <= '0; opwr_q <= '0;
      end else begin
         acc_q <= acc_d; snap_q <= snap_d; cnt_q <= cnt_d;
         snap_rdy_q <= snap_rdy_d; drop_q <= drop_d;
         state_q <= state_d; j_q <= j_d; pass_q <= pass_d; mask_q <= mask_d;
         have_q <= have_d; bidx_q <= bidx_d; bpwr_q <= bpwr_d;
         ridx_q <= ridx_d; rpwr_q <= rpwr_d; oidx_q <= oidx_d; opwr_q <= opwr_d;
      end
   end

   assign o_beam_idx  = oidx_q;
   assign o_beam_pwr  = opwr_q;
   assign o_idx_valid = (state_q == EMIT);
   assign o_busy      = (state_q != IDLE);
   assign o_drop      = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_beam_pwr_topk.sv
`default_nettype none
// ============================================================================
// tb_beam_pwr_topk: directed bench for beam_pwr_topk (NRE=80 main, NRE=8 overrun).
// Revision: 1.0
// ============================================================================
module tb_beam_pwr_topk;
   localparam int BEAM = 16;
   localparam int OW   = 48;
   localparam int SW   = 24;
   localparam int K    = 4;
   localparam int AW   = 64;
   localparam int IDXW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [BEAM-1:0][2*OW-1:0] sum_data = '0;
   logic tvalid = 1'b0;
   logic sym_start = 1'b0;

   logic [K-1:0][IDXW-1:0] idx_a, idx_b;
   logic [K-1:0][AW-1:0]   pwr_a, pwr_b;
   logic va, vb, busy_a, busy_b, drop_a, drop_b;

   beam_pwr_topk #(.BEAM(BEAM), .OW(OW), .SW(SW), .NRE(80), .K(K), .AW(AW)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sum_data(sum_data), .i_tvalid(tvalid),
      .i_sym_start(sym_start), .o_beam_idx(idx_a), .o_beam_pwr(pwr_a),
      .o_idx_valid(va), .o_busy(busy_a), .o_drop(drop_a));

   beam_pwr_topk #(.BEAM(BEAM), .OW(OW), .SW(SW), .NRE(8), .K(K), .AW(AW)) u_ovr (
      .i_clk(clk), .i_rst_n(rst_n), .i_sum_data(sum_data), .i_tvalid(tvalid),
      .i_sym_start(sym_start), .o_beam_idx(idx_b), .o_beam_pwr(pwr_b),
      .o_idx_valid(vb), .o_busy(busy_b), .o_drop(drop_b));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;
   int n_pa = 0, n_pb = 0, n_da = 0, n_db = 0;
   int last_cyc = 0;
   int cap_cyc [0:15];
   logic [K-1:0][IDXW-1:0] cap_idx [0:15];
   logic [K-1:0][AW-1:0]   cap_pwr [0:15];
   logic [K-1:0][AW-1:0]   cap_pwr_b;
   logic [K-1:0][IDXW-1:0] cap_idx_b;
   int re_v [BEAM];
   int im_v [BEAM];

   always @(negedge clk) begin
      if (va) begin
         cap_cyc[n_pa & 15] = cyc;
         cap_idx[n_pa & 15] = idx_a;
         cap_pwr[n_pa & 15] = pwr_a;
         n_pa++;
      end
      if (vb) begin
         cap_idx_b = idx_b;
         cap_pwr_b = pwr_b;
         n_pb++;
      end
      if (drop_a) n_da++;
      if (drop_b) n_db++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Truncated bits below the retained field carry junk that must be ignored.
   function automatic logic [OW-1:0] fld(input int v);
      logic [OW-1:0] f;
      f = OW'(longint'(v)) << (OW - SW);
      return f | 48'h5A5A5A;
   endfunction

   task automatic load_pat();
      for (int b = 0; b < BEAM; b++) sum_data[b] = {fld(re_v[b]), fld(im_v[b])};
   endtask

   task automatic set_lin(input bit rev);
      for (int b = 0; b < BEAM; b++) begin
         re_v[b] = rev ? (BEAM - 1 - b) : b;
         im_v[b] = 0;
      end
   endtask

   task automatic send_sym(input int n, input int maxgap);
      load_pat();
      for (int i = 0; i < n; i++) begin
         if (maxgap > 0) begin
            repeat ($urandom_range(0, maxgap)) begin
               @(negedge clk);
               tvalid = 1'b0;
               sym_start = 1'b0;
            end
         end
         @(negedge clk);
         tvalid = 1'b1;
         sym_start = (i == 0);
      end
      last_cyc = cyc + 1;
      @(negedge clk);
      tvalid = 1'b0;
      sym_start = 1'b0;
   endtask

   task automatic wait_pulse(input int target, input string tag);
      int n;
      n = 0;
      while (n_pa < target && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      chk(tag, n_pa, target);
   endtask

   task automatic check_res(input string t, input int p,
                            input int i0, input int i1, input int i2, input int i3,
                            input longint q0, input longint q1, input longint q2, input longint q3);
      int ei [4];
      longint ep [4];
      ei = '{i0, i1, i2, i3};
      ep = '{q0, q1, q2, q3};
      for (int k = 0; k < K; k++) begin
         chk($sformatf("%s idx%0d", t, k), 64'(cap_idx[p & 15][k]), 64'(ei[k]));
         chk($sformatf("%s pwr%0d", t, k), cap_pwr[p & 15][k], ep[k]);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   int base_p, base_d, base_pb, base_db;

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst idx", 64'(idx_a), 64'd0);
      chk("rst pwr", pwr_a[0] | pwr_a[3], 64'd0);
      chk("rst valid", 64'(va), 64'd0);
      chk("rst busy", 64'(busy_a), 64'd0);
      chk("rst drop", 64'(drop_a), 64'd0);
      rst_n = 1'b1;

      // Basic ranking with latency and busy checks
      set_lin(1'b0);
      base_p = n_pa;
      send_sym(80, 0);
      repeat (4) @(negedge clk);
      #1;
      chk("busy in scan", 64'(busy_a), 64'd1);
      wait_pulse(base_p + 1, "basic pulse");
      check_res("basic", base_p, 15, 14, 13, 12, 18000, 15680, 13520, 11520);
      chk("basic latency", 64'(cap_cyc[base_p & 15] - last_cyc), 64'd68);
      @(negedge clk); #1;
      chk("pulse width", 64'(va), 64'd0);
      chk("hold idx0", 64'(idx_a[0]), 64'd15);
      chk("idle busy", 64'(busy_a), 64'd0);

      // Ties and sign
      for (int b = 0; b < BEAM; b++) begin
         re_v[b] = -3;
         im_v[b] = 4;
      end
      re_v[7] = 6;
      im_v[7] = 0;
      base_p = n_pa;
      send_sym(80, 0);
      wait_pulse(base_p + 1, "ties pulse");
      check_res("ties", base_p, 7, 0, 1, 2, 2880, 2000, 2000, 2000);

      // Back-to-back symbols with gaps
      base_p = n_pa;
      base_d = n_da;
      set_lin(1'b0);
      send_sym(80, 2);
      set_lin(1'b1);
      send_sym(80, 2);
      wait_pulse(base_p + 2, "b2b pulses");
      check_res("b2b first", base_p, 15, 14, 13, 12, 18000, 15680, 13520, 11520);
      check_res("b2b second", base_p + 1, 0, 1, 2, 3, 18000, 15680, 13520, 11520);
      chk("b2b drops", 64'(n_da - base_d), 64'd0);

      // Overrun on the NRE=8 instance
      do_reset();
      base_pb = n_pb;
      base_db = n_db;
      set_lin(1'b0);
      send_sym(8, 0);
      send_sym(8, 0);
      repeat (150) @(negedge clk);
      #1;
      chk("ovr pulses", 64'(n_pb - base_pb), 64'd1);
      chk("ovr drops", 64'(n_db - base_db), 64'd1);
      chk("ovr idx0", 64'(cap_idx_b[0]), 64'd15);
      chk("ovr pwr0", cap_pwr_b[0], 64'd1800);
      chk("ovr pwr3", cap_pwr_b[3], 64'd1152);

      // Restart mid-symbol
      do_reset();
      base_p = n_pa;
      base_d = n_da;
      for (int b = 0; b < BEAM; b++) begin
         re_v[b] = 20;
         im_v[b] = 0;
      end
      send_sym(40, 0);
      set_lin(1'b0);
      send_sym(80, 0);
      wait_pulse(base_p + 1, "restart pulse");
      check_res("restart", base_p, 15, 14, 13, 12, 18000, 15680, 13520, 11520);
      repeat (100) @(negedge clk);
      #1;
      chk("restart pulses", 64'(n_pa - base_p), 64'd1);
      chk("restart drops", 64'(n_da - base_d), 64'd0);

      // Reset during SCAN
      base_p = n_pa;
      set_lin(1'b1);
      send_sym(80, 0);
      repeat (20) @(negedge clk);
      chk("pre-rst busy", 64'(busy_a), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst idx", 64'(idx_a), 64'd0);
      chk("midrst pwr0", pwr_a[0], 64'd0);
      chk("midrst busy", 64'(busy_a), 64'd0);
      chk("midrst valid", 64'(va), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      #1;
      chk("midrst no emit", 64'(n_pa - base_p), 64'd0);
      set_lin(1'b1);
      send_sym(80, 0);
      wait_pulse(base_p + 1, "post-rst pulse");
      check_res("post-rst", base_p, 0, 1, 2, 3, 18000, 15680, 13520, 11520);
      chk("post-rst latency", 64'(cap_cyc[base_p & 15] - last_cyc), 64'd68);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end
endmodule
`default_nettype wire
